// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap timer: status encodings,
// seconds limits and the seconds clamp used when presetting the count.
package lap_timer_pkg;

  localparam int unsigned SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } status_t;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/lap_timer_tick_prescaler.sv
// Divides clk by CLK_DIV while enabled; tick_c marks the last cycle of each period.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tick_c ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/lap_timer.sv
// Minutes:seconds up/down timer with split capture, preset load and
// wrap/expiry event pulses.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned MIN_W   = 8,
  parameter int unsigned MIN_MAX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             load,
  input  logic             dir,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             wrap,
  output logic             expired
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);

  status_t          state, state_d;
  logic [MIN_W-1:0] min_d, lap_min_d;
  logic [5:0]       sec_d, lap_sec_d;
  logic             lap_valid_d, wrap_d, exp_pend, exp_pend_d, dir_q, dir_d;
  logic             tick_c, expire_c, pre_clr_c;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (state == ST_RUNNING),
    .clr    (pre_clr_c),
    .tick_c (tick_c)
  );

  assign status   = state;
  assign expire_c = tick_c && dir_q && (minutes == '0) && (seconds == 6'd1);

  // Next-state: tick first, then lap, then the command chain may override.
  always_comb begin
    state_d     = state;
    min_d       = minutes;
    sec_d       = seconds;
    lap_min_d   = lap_min;
    lap_sec_d   = lap_sec;
    lap_valid_d = lap_valid;
    wrap_d      = 1'b0;
    exp_pend_d  = 1'b0;
    dir_d       = dir_q;
    pre_clr_c   = 1'b0;

    if (tick_c) begin
      if (!dir_q) begin
        if (seconds == SEC_MAX) begin
          sec_d = '0;
          if (minutes == MIN_TOP) begin
            min_d  = '0;
            wrap_d = 1'b1;
          end else begin
            min_d = minutes + MIN_W'(1);
          end
        end else begin
          sec_d = seconds + 6'd1;
        end
      end else begin
        if (seconds == '0) begin
          sec_d = SEC_MAX;
          min_d = minutes - MIN_W'(1);
        end else begin
          sec_d = seconds - 6'd1;
        end
        if (expire_c) begin
          state_d    = ST_EXPIRED;
          exp_pend_d = 1'b1;
        end
      end
    end

    if (lap && (state == ST_RUNNING || state == ST_PAUSED)) begin
      lap_min_d   = minutes;
      lap_sec_d   = seconds;
      lap_valid_d = 1'b1;
    end

    if (clear) begin
      state_d     = ST_IDLE;
      min_d       = '0;
      sec_d       = '0;
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_valid_d = 1'b0;
      wrap_d      = 1'b0;
      exp_pend_d  = 1'b0;
      pre_clr_c   = 1'b1;
    end else if (load) begin
      if (state != ST_RUNNING) begin
        min_d     = (load_min > MIN_TOP) ? MIN_TOP : load_min;
        sec_d     = clamp_sec(load_sec);
        pre_clr_c = 1'b1;
        if (state == ST_EXPIRED) state_d = ST_IDLE;
      end
    end else if (stop) begin
      if (state == ST_RUNNING && !expire_c) state_d = ST_PAUSED;
    end else if (start) begin
      // A down-count from 00:00 would underflow, so it never starts.
      if ((state == ST_IDLE || state == ST_PAUSED) &&
          !(dir && minutes == '0 && seconds == '0)) begin
        state_d = ST_RUNNING;
        dir_d   = dir;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      minutes   <= '0;
      seconds   <= '0;
      lap_min   <= '0;
      lap_sec   <= '0;
      lap_valid <= 1'b0;
      wrap      <= 1'b0;
      exp_pend  <= 1'b0;
      expired   <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state     <= state_d;
      minutes   <= min_d;
      seconds   <= sec_d;
      lap_min   <= lap_min_d;
      lap_sec   <= lap_sec_d;
      lap_valid <= lap_valid_d;
      wrap      <= wrap_d;
      exp_pend  <= exp_pend_d;
      expired   <= exp_pend;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench: three lap_timer configurations driven by one command stream.
module tb_lap_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 0, stop = 0, clear = 0, lap = 0, load = 0, dir = 0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;

  logic [7:0] a_min, a_lmin, b_min, b_lmin, c_min, c_lmin;
  logic [5:0] a_sec, a_lsec, b_sec, b_lsec, c_sec, c_lsec;
  logic [1:0] a_st, b_st, c_st;
  logic       a_lv, a_wrap, a_exp, b_lv, b_wrap, b_exp, c_lv, c_wrap, c_exp;

  int n_checks = 0;
  int n_pass   = 0;
  int a_wraps  = 0;
  int b_wraps  = 0;

  always #5 clk = ~clk;

  lap_timer #(.CLK_DIV(4), .MIN_W(8), .MIN_MAX(99)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .load(load), .dir(dir), .load_min(load_min), .load_sec(load_sec),
    .minutes(a_min), .seconds(a_sec), .lap_min(a_lmin), .lap_sec(a_lsec),
    .lap_valid(a_lv), .status(a_st), .wrap(a_wrap), .expired(a_exp));

  lap_timer #(.CLK_DIV(1), .MIN_W(8), .MIN_MAX(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .load(load), .dir(dir), .load_min(load_min), .load_sec(load_sec),
    .minutes(b_min), .seconds(b_sec), .lap_min(b_lmin), .lap_sec(b_lsec),
    .lap_valid(b_lv), .status(b_st), .wrap(b_wrap), .expired(b_exp));

  lap_timer #(.CLK_DIV(1), .MIN_W(8), .MIN_MAX(99)) u_c (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .load(load), .dir(dir), .load_min(load_min), .load_sec(load_sec),
    .minutes(c_min), .seconds(c_sec), .lap_min(c_lmin), .lap_sec(c_lsec),
    .lap_valid(c_lv), .status(c_st), .wrap(c_wrap), .expired(c_exp));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [5:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start(input logic d);
    start = 1'b1; dir = d;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic check_zero_c(input string tag);
    check({tag, "_min"},  c_min,  0);
    check({tag, "_sec"},  c_sec,  0);
    check({tag, "_lmin"}, c_lmin, 0);
    check({tag, "_lsec"}, c_lsec, 0);
    check({tag, "_lv"},   c_lv,   0);
    check({tag, "_wrap"}, c_wrap, 0);
    check({tag, "_exp"},  c_exp,  0);
    check({tag, "_st"},   c_st,   0);
  endtask

  initial begin
    // reset state
    cycle();
    cycle();
    check_zero_c("rst");
    check("rst_a_st", a_st, 0);
    rst = 1'b0;
    cycle();

    // lap in IDLE is ignored
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    check("lap_idle_lv", c_lv, 0);

    // CLK_DIV=4 up count: 240 cycles -> 01:00, no wrap
    do_start(1'b0);
    check("div4_start_st", a_st, 1);
    for (int i = 0; i < 240; i++) begin
      cycle();
      if (a_wrap) a_wraps++;
      if (b_wrap) b_wraps++;
    end
    check("div4_min", a_min, 1);
    check("div4_sec", a_sec, 0);
    check("div4_st", a_st, 1);
    check("div4_wraps", a_wraps, 0);
    check("max2_wraps", b_wraps, 1);
    check("max2_min", b_min, 1);
    check("max2_sec", b_sec, 0);
    check("div1_min", c_min, 4);

    // load while RUNNING is ignored
    do_load(8'd5, 6'd5);
    check("load_run_min", a_min, 1);
    check("load_run_sec", a_sec, 0);
    do_clear();
    check("clr_a_min", a_min, 0);
    check("clr_a_st", a_st, 0);

    // MIN_MAX=2 wrap from 02:59
    do_load(8'd2, 6'd59);
    check("wrap_load_min", b_min, 2);
    check("wrap_load_sec", b_sec, 59);
    do_start(1'b0);
    check("wrap_pre_sec", b_sec, 59);
    cycle();
    check("wrap_min", b_min, 0);
    check("wrap_sec", b_sec, 0);
    check("wrap_pulse", b_wrap, 1);
    check("wrap_st", b_st, 1);
    cycle();
    check("wrap_pulse_end", b_wrap, 0);
    check("wrap_next_sec", b_sec, 1);
    do_clear();

    // down count 00:02 -> expiry
    do_load(8'd0, 6'd2);
    do_start(1'b1);
    check("dn_start_st", c_st, 1);
    check("dn_start_sec", c_sec, 2);
    cycle();
    check("dn_sec1", c_sec, 1);
    cycle();
    check("dn_sec0", c_sec, 0);
    check("dn_min0", c_min, 0);
    check("dn_st_exp", c_st, 3);
    check("dn_exp_early", c_exp, 0);
    cycle();
    check("dn_exp_pulse", c_exp, 1);
    check("dn_hold_sec", c_sec, 0);
    cycle();
    check("dn_exp_end", c_exp, 0);
    do_start(1'b0);
    check("dn_start_ign", c_st, 3);
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    check("dn_lap_ign", c_lv, 0);
    do_load(8'd0, 6'd0);
    check("dn_load_idle", c_st, 0);
    do_start(1'b1);
    check("dn_zero_start_ign", c_st, 0);
    dir = 1'b0;
    do_clear();

    // load clamping
    do_load(8'd0, 6'd62);
    check("clamp_sec", c_sec, 59);
    check("clamp_sec_min", c_min, 0);
    do_load(8'd150, 6'd10);
    check("clamp_min", c_min, 99);
    check("clamp_min_sec", c_sec, 10);
    check("clamp_min_max2", b_min, 2);
    do_clear();

    // lap coincident with tick, stop+start, clear
    do_load(8'd0, 6'd5);
    do_start(1'b0);
    check("lap_pre_sec", c_sec, 5);
    lap = 1'b1;
    cycle();
    lap = 1'b0;
    check("lap_min", c_lmin, 0);
    check("lap_sec", c_lsec, 5);
    check("lap_valid", c_lv, 1);
    check("lap_count", c_sec, 6);
    stop = 1'b1; start = 1'b1;
    cycle();
    stop = 1'b0; start = 1'b0;
    check("stopstart_st", c_st, 2);
    check("stopstart_sec", c_sec, 7);
    cycle();
    check("paused_hold", c_sec, 7);
    do_clear();
    check_zero_c("clear");

    // async reset while RUNNING at 00:30
    do_load(8'd0, 6'd30);
    do_start(1'b0);
    check("pre_rst_sec", c_sec, 30);
    #2;
    rst = 1'b1;
    #1;
    check_zero_c("arst");
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_wrap", c_wrap, 0);
    check("post_rst_exp", c_exp, 0);
    do_start(1'b0);
    check("post_rst_start", c_st, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
